// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and width helpers.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor slice: x - y - bin.
// Produces the difference bit and the outgoing borrow.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow out when y (plus incoming borrow) exceeds x.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor slice.
// Operands and result move over valid/ready handshakes.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            cnt_q     <= '0;
            br_q      <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            cnt_q     <= cnt_d;
            br_q      <= br_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
        end
    end

    // Next-state, datapath shift and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        cnt_d     = cnt_q;
        br_d      = br_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        diff      = '0;
        borrow    = 1'b0;
        ovf       = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    a_msb_d   = a[WIDTH-1];
                    b_msb_d   = b[WIDTH-1];
                    br_d      = 1'b0;
                    cnt_d     = '0;
                    diff_sr_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                diff_sr_d = {fs_d, diff_sr_q[WIDTH-1:1]};
                br_d      = fs_bout;
                a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                diff      = diff_sr_q;
                borrow    = br_q;
                // Overflow only possible when operand signs differ.
                ovf       = (a_msb_q != b_msb_q) &&
                            (diff_sr_q[WIDTH-1] != a_msb_q);
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised bench for serial_subtractor against an arithmetic model.
// Directed cases pin the model with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int n_assert = 0;
    int n_fail   = 0;

    logic         mdl_idle;
    int           mdl_left;
    logic         mdl_done;
    logic [W-1:0] mdl_diff;
    logic         mdl_borrow;
    logic         mdl_ovf;

    logic [W-1:0] cap_diff;
    logic         cap_borrow;
    logic         cap_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic sovf(input logic [W-1:0] x,
                                  input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    endfunction

    // Transaction-level model: accept, W cycles of work, hold until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_idle   <= 1'b1;
            mdl_left   <= 0;
            mdl_done   <= 1'b0;
            mdl_diff   <= '0;
            mdl_borrow <= 1'b0;
            mdl_ovf    <= 1'b0;
        end else if (mdl_idle) begin
            if (in_valid) begin
                mdl_idle   <= 1'b0;
                mdl_left   <= W;
                mdl_diff   <= a - b;
                mdl_borrow <= (a < b);
                mdl_ovf    <= sovf(a, b);
            end
        end else if (mdl_left > 0) begin
            mdl_left <= mdl_left - 1;
            if (mdl_left == 1) mdl_done <= 1'b1;
        end else if (mdl_done && out_ready) begin
            mdl_done <= 1'b0;
            mdl_idle <= 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(mdl_idle));
        chk("out_valid", 32'(out_valid), 32'(mdl_done));
        chk("diff", 32'(diff), mdl_done ? 32'(mdl_diff) : 32'd0);
        chk("borrow", 32'(borrow), 32'(mdl_done & mdl_borrow));
        chk("ovf", 32'(ovf), 32'(mdl_done & mdl_ovf));
    end

    task automatic start_op(input logic [W-1:0] ta,
                            input logic [W-1:0] tb_v);
        int n;
        @(negedge clk);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        cap_diff   = diff;
        cap_borrow = borrow;
        cap_ovf    = ovf;
    endtask

    task automatic end_op(input int stall);
        repeat (stall) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input int stall);
        start_op(ta, tb_v);
        wait_res();
        end_op(stall);
    endtask

    task automatic lit(input string nm, input logic [W-1:0] ed,
                       input logic eb, input logic eo);
        chk({nm, "_diff"}, 32'(cap_diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(cap_borrow), 32'(eb));
        chk({nm, "_ovf"}, 32'(cap_ovf), 32'(eo));
        chk({nm, "_model"}, 32'({mdl_diff, mdl_borrow, mdl_ovf}),
            32'({ed, eb, eo}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        do_op(8'h05, 8'h03, 0);
        lit("basic", 8'h02, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 0);
        lit("borrow", 8'hFE, 1'b1, 1'b0);
        do_op(8'h00, 8'hFF, 0);
        lit("zero_ff", 8'h01, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 0);
        lit("minneg", 8'h7F, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 1);
        lit("ovf2", 8'h80, 1'b1, 1'b1);
        do_op(8'h3C, 8'h3C, 2);
        lit("equal", 8'h00, 1'b0, 1'b0);

        // Backpressure with a competing request held on the input.
        start_op(8'h10, 8'h10);
        a = 8'hAA;
        b = 8'h0F;
        in_valid = 1'b1;
        wait_res();
        lit("bp", 8'h00, 1'b0, 1'b0);
        end_op(5);
        @(negedge clk);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_res();
        lit("bp_next", 8'h9B, 1'b0, 1'b0);
        end_op(0);

        // Asynchronous reset between edges, mid-shift.
        start_op(8'h55, 8'h22);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'hFF, 8'hFF, 0);
        lit("post_rst", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            do_op(ra, rb, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor: the difference-producing counterpart to the team's combinational adder cell. Computes diff = a - b one bit per clock, LSB first, through a single 1-bit full-subtractor slice. Operands enter and results leave through valid/ready handshakes. Used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend (unsigned or two's complement)
b  input  WIDTH  subtrahend
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow  output  1  1 iff a < b unsigned
ovf  output  1  signed overflow of a - b

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n); rst_n low clears all state immediately, independent of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, ovf=0, counter=0, internal shift regs=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On the edge where in_valid&&in_ready: latch a->A_sr, b->B_sr, a[MSB]->a_msb, b[MSB]->b_msb; clear br, cnt and diff_sr; go SHIFT.
- SHIFT (exactly WIDTH cycles): in_ready=0, out_valid=0. Each edge:
  - d = A_sr[0]^B_sr[0]^br
  - br <= (~A_sr[0]&B_sr[0]) | (~(A_sr[0]^B_sr[0])&br)
  - diff_sr <= {d, diff_sr[WIDTH-1:1]}
  - A_sr, B_sr shift right by 1; cnt++
  - When cnt==WIDTH-1 on this edge: go DONE.
- DONE:
  - out_valid=1; diff=diff_sr; borrow=br; ovf=(a_msb!=b_msb)&&(diff_sr[WIDTH-1]!=a_msb).
  - Outputs held stable while out_ready=0.
  - On out_valid&&out_ready: go IDLE.
- Latency: accept edge k; out_valid high after edge k+WIDTH. Minimum issue interval is WIDTH+2 cycles: the DONE handshake edge, one IDLE cycle, then accept.
- in_ready is asserted only in IDLE. in_valid in SHIFT/DONE is ignored, with no latching or queuing.
- Outputs (diff, borrow, ovf) read 0 outside DONE.
- Reset mid-operation (SHIFT or DONE) aborts the operation; no partial result is ever presented.
- Width rules: internal counter is $clog2(WIDTH) bits. No carry-in; the initial borrow is always 0.
- Boundaries:
  - a==b -> diff=0, borrow=0, ovf=0.
  - a=0, b=2^WIDTH-1 -> diff=1, borrow=1.
  - Most-negative minus 1 -> ovf=1.

Decomposition:
- Package sub_pkg:
  - typedef enum for state (IDLE, SHIFT, DONE)
  - default WIDTH constant
  - counter-width helper constant
- Sub-module full_subtractor: combinational 1-bit slice, inputs x, y, bin; outputs d, bout. Instantiated once in serial_subtractor.

Test Plan:
- Reset: hold rst_n=0, toggle clk -> in_ready=1, out_valid=0, diff=0x00, borrow=0, ovf=0. Assert rst_n low asynchronously between edges -> outputs clear immediately.
- Basic: WIDTH=8, a=0x05, b=0x03, out_ready=1 -> out_valid high 8 edges after accept, diff=0x02, borrow=0, ovf=0, in_ready=0 throughout SHIFT.
- Borrow: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0. Also a=0x00, b=0xFF -> diff=0x01, borrow=1.
- Signed overflow: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- Backpressure: a=0x10, b=0x10, out_ready=0 for 5 cycles -> out_valid, diff=0x00, borrow=0 stable. A new in_valid with a=0xAA is not accepted (in_ready=0). Raise out_ready -> one handshake, IDLE next cycle, then 0xAA accepted.
- Reset mid-op: start a=0x55, b=0x22; drop rst_n after 3 SHIFT cycles -> all state cleared, out_valid never asserted. Next op a=0xFF, b=0xFF -> diff=0x00, borrow=0.
